// File: rtl/up_sampler_if.sv
// up_sampler_if
//   Stream bundle for the up_sampler: a low-rate input sample channel and a
//   high-rate output sample channel. Both use valid/ready handshakes.
//   A beat transfers on a rising clock edge where valid and ready are both 1.
//   While valid is 1 and ready is 0, the sender holds its payload stable.
//
//   Signals:
//     data_in        low-rate input sample
//     data_in_vld    data_in valid
//     data_in_rdy    block can accept data_in this cycle
//     zero_stuff     mode select, captured with each accepted sample
//     data_out       high-rate output sample
//     data_out_vld   data_out valid
//     data_out_rdy   downstream accepts data_out this cycle
//     data_out_first marks copy 0 of each burst, qualified by data_out_vld
//     state_dbg      debug view of the FSM state (0 = IDLE, 1 = EMIT)
//
//   Modports:
//     slave  - the up_sampler side
//     master - the side that feeds samples in and consumes the output
interface up_sampler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_vld;
    logic                  data_in_rdy;
    logic                  zero_stuff;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_vld;
    logic                  data_out_rdy;
    logic                  data_out_first;
    logic                  state_dbg;

    modport slave (
        input  data_in,
        input  data_in_vld,
        input  zero_stuff,
        input  data_out_rdy,
        output data_in_rdy,
        output data_out,
        output data_out_vld,
        output data_out_first,
        output state_dbg
    );

    modport master (
        output data_in,
        output data_in_vld,
        output zero_stuff,
        output data_out_rdy,
        input  data_in_rdy,
        input  data_out,
        input  data_out_vld,
        input  data_out_first,
        input  state_dbg
    );
endinterface

// File: rtl/up_sampler.sv
// up_sampler
//   Integer-factor interpolator. Each accepted input sample produces a burst
//   of exactly UP_SAMPLE_BY output beats.
//   - Hold mode (zero_stuff = 0): every copy repeats the sample.
//   - Zero-stuff mode (zero_stuff = 1): copy 0 carries the sample and the
//     remaining copies are zero.
//   A new sample is accepted combinationally on the last-copy transfer, so
//   back-to-back bursts run with no bubble.
//
//   Ports:
//     clk   clock; all logic runs on the rising edge
//     rstn  asynchronous active-low reset
//     s     up_sampler_if.slave stream bundle (see up_sampler_if.sv)
//
//   Parameters:
//     DATA_WIDTH    sample width in bits
//     UP_SAMPLE_BY  interpolation factor, 2..256
module up_sampler #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int UP_SAMPLE_BY = 10,
    localparam int CNT_WIDTH    = $clog2(UP_SAMPLE_BY)
) (
    input  logic           clk,
    input  logic           rstn,
    up_sampler_if.slave    s
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(UP_SAMPLE_BY - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  mode_q, mode_d;

    logic last;
    logic in_rdy;
    logic out_vld;
    logic ia;
    logic ot;

    // Handshake terms shared by the next-state and output logic.
    // in_rdy depends combinationally on data_out_rdy, so a new sample can be
    // taken on the same edge that retires the last copy. It is held low
    // during reset so that no output is asserted while rstn is low.
    always_comb begin
        last    = (state_q == EMIT) && (cnt_q == LAST_CNT);
        out_vld = (state_q == EMIT);
        in_rdy  = rstn && ((state_q == IDLE) || (last && s.data_out_rdy));
        ia      = s.data_in_vld && in_rdy;
        ot      = out_vld && s.data_out_rdy;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ia) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // Leave EMIT only when the last copy transfers and no new
                // sample arrives on the same edge.
                if (ot && last && !ia) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Without a transfer everything holds, which keeps
    // data_out stable under backpressure. In EMIT, ia can only be true on a
    // last-copy transfer, so loading takes priority over counting.
    always_comb begin
        cnt_d    = cnt_q;
        sample_d = sample_q;
        mode_d   = mode_q;
        if (ia) begin
            sample_d = s.data_in;
            mode_d   = s.zero_stuff;
            cnt_d    = '0;
        end else if (ot) begin
            cnt_d = last ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    // Outputs. All outputs are zero during reset: the registers clear
    // asynchronously, and in_rdy is gated by rstn.
    always_comb begin
        s.data_in_rdy    = in_rdy;
        s.data_out_vld   = out_vld;
        s.data_out       = ((cnt_q == '0) || !mode_q) ? sample_q : '0;
        s.data_out_first = out_vld && (cnt_q == '0);
        s.state_dbg      = state_q;
    end

endmodule

// File: doc/up_sampler.md
# up_sampler

Integer-factor interpolator forming the transmit-side counterpart of the decimation stage in the phase-noise measurement datapath. It accepts one input sample through a valid/ready handshake and emits UP_SAMPLE_BY output samples, one per accepted output beat, in either zero-order-hold or zero-stuffing mode. It sits between a low-rate sample source (FW-loaded buffer or DSP stage) and a full-rate consumer, and restores the sample rate that the down-sampler reduced.

## Interface
- DATA_WIDTH, 32, sample width in bits
- UP_SAMPLE_BY, 10, interpolation factor; legal range 2..256
- CNT_WIDTH, $clog2(UP_SAMPLE_BY), derived width of the copy counter; not overridden
- clk  input  1  single clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- data_in  input  DATA_WIDTH  low-rate input sample
- data_in_vld  input  1  data_in valid
- data_in_rdy  output  1  block can accept data_in this cycle
- zero_stuff  input  1  mode select, sampled on input accept: 1 = zero-stuff, 0 = hold
- data_out  output  DATA_WIDTH  high-rate output sample
- data_out_vld  output  1  data_out valid
- data_out_rdy  input  1  downstream accepts data_out this cycle
- data_out_first  output  1  marks copy 0 of each burst; qualified by data_out_vld

## Operation
- Handshakes:
  - Input accept (IA) = data_in_vld & data_in_rdy.
  - Output transfer (OT) = data_out_vld & data_out_rdy.
- Registers:
  - state: IDLE or EMIT.
  - cnt: CNT_WIDTH bits, copy index.
  - sample_reg: DATA_WIDTH bits.
  - mode_reg: 1 bit.
- last = (state == EMIT) & (cnt == UP_SAMPLE_BY-1).
- data_in_rdy = (state == IDLE) | (last & data_out_rdy). This is combinational from data_out_rdy and allows back-to-back bursts with no bubble. It is forced 0 while rstn is low.
- IDLE:
  - data_out_vld = 0.
  - On IA: sample_reg <= data_in, mode_reg <= zero_stuff, cnt <= 0, go to EMIT.
- EMIT:
  - data_out_vld = 1.
  - On OT with !last: cnt <= cnt + 1.
  - On OT with last and IA: load the new sample and mode, cnt <= 0, stay in EMIT.
  - On OT with last and no IA: go to IDLE, cnt <= 0.
  - With no OT: cnt, sample_reg and mode_reg hold, so data_out stays stable under backpressure.
- data_out = sample_reg when (cnt == 0) | !mode_reg; otherwise all zeros.
- data_out_first = data_out_vld & (cnt == 0).
- data_in is ignored when data_in_rdy = 0. zero_stuff is only sampled at IA; a mid-burst change has no effect.
- Counter width: cnt never exceeds UP_SAMPLE_BY-1. There is no hardcoded terminal value; the compare is against the parameter at CNT_WIDTH width.
- Reset:
  - All outputs are 0 while rstn is low.
  - After reset: state = IDLE, cnt = 0, sample_reg = 0, mode_reg = 0.
  - Reset asserted mid-burst abandons the burst. No remaining copies are emitted after release.

## Timing
- Latency: IA at edge k makes data_out_vld = 1 with copy 0 on the cycle after edge k. The earliest OT of copy 0 is at edge k+1.
- Burst length: exactly UP_SAMPLE_BY OTs per accepted sample.
- Throughput:
  - With data_out_rdy held at 1 and an input offered every UP_SAMPLE_BY cycles, data_out_vld stays continuously 1.
  - Input throughput is 1 sample per UP_SAMPLE_BY cycles.
- Backpressure: each cycle of data_out_rdy = 0 extends the burst by one cycle. The next data_in_rdy is delayed by the same amount.
- Simultaneous last-copy OT and IA at the same edge: the new sample's copy 0 appears the next cycle, with no gap in data_out_vld.
- First cycle after rstn deasserts: data_in_rdy = 1, data_out_vld = 0.

## Test plan
- Hold mode, single sample:
  - Stimulus: UP_SAMPLE_BY = 10, zero_stuff = 0, data_out_rdy = 1, data_in = 0x0000_00A5 accepted at edge 0.
  - Response: data_out = 0x0000_00A5 with vld = 1 for exactly 10 cycles; data_out_first = 1 only on the first of them; then vld = 0 and data_in_rdy = 1.
- Zero-stuff mode:
  - Stimulus: zero_stuff = 1, data_in = 0x1234_5678.
  - Response: outputs are 0x1234_5678 then 9 zeros; data_out_first is aligned with the nonzero sample.
- Back-to-back streaming:
  - Stimulus: 3 samples 0x1, 0x2, 0x3, each offered with data_in_vld held high.
  - Response: 30 consecutive valid cycles with no gap; each new sample is accepted exactly on the last-copy cycle of the previous one; data_in_rdy = 0 on all other EMIT cycles.
- Backpressure:
  - Stimulus: data_out_rdy = 0 for cycles 3..6 of a burst.
  - Response: data_out and cnt stay frozen at copy 3 for those cycles; the burst still delivers exactly 10 OTs, with the final one 4 cycles later than without the stall.
- Mode change mid-burst:
  - Stimulus: toggle zero_stuff during EMIT.
  - Response: the current burst is unaffected; the new mode applies only to the next accepted sample.
- Reset mid-burst:
  - Stimulus: assert rstn low during copy 5, then release.
  - Response: data_out_vld, data_out and data_out_first drop to 0 immediately, asynchronously. After release, no residual copies appear and data_in_rdy = 1 on the first clock.
